// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: lookup, line-fill and write-through sequencer for a direct-mapped 256 x 16-byte cache.
// Define CACHE_STATS_EN to add the hit_count/miss_count outputs.
module cache_line_ctrl #(
   parameter int FILL_BURST = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] req_address,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [31:0]       req_writedata,
   input  logic [3:0]        req_byteenable,
   output logic              req_done,
   output logic [127:0]      req_readdata,
   input  logic              invalidate_all,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_read_do,
   input  logic [147:0]      ram_q,
   output logic              ram_write_do,
   output logic [127:0]      ram_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_burstcount,
   output logic [31:0]       mem_writedata,
   output logic [3:0]        mem_byteenable,
   input  logic              mem_waitrequest,
   input  logic              mem_readdatavalid,
   input  logic [31:0]       mem_readdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_DATA, FILL_WRITE, WRITE_MEM} state_t;
   state_t state_q, state_d;
   logic [255:0] valid_q, valid_d;
   logic flush_q, flush_d;
   logic [1:0] cnt_q, cnt_d;
   logic [127:0] line_q, line_d;
   logic req_done_q, req_done_d;
   logic [127:0] rdata_q, rdata_d;
   logic ram_write_do_q, ram_write_do_d;
   logic mem_read_q, mem_read_d;
   logic mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [2:0] burst_q, burst_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0] be_q, be_d;
   logic [31:0] hits_q, hits_d, misses_q, misses_d;
   logic [7:0] idx;
   logic hit, idle_go;
   assign idx = req_address[11:4];
   assign hit = valid_q[idx] && ram_q[147:128] == req_address[ADDR_W-1:12];
   // The cycle that shows req_done must not re-accept the still-held request.
   assign idle_go = state_q == IDLE && !flush_q && !invalidate_all && !req_done_q;
   // The RAM strobe is combinational so its registered q lands in LOOKUP.
   assign ram_read_do = !rst && idle_go && !req_write && req_read;
   assign ram_address = (ram_read_do || ram_write_do_q) ? req_address : '0;
   assign ram_write_do = ram_write_do_q;
   assign ram_data = line_q;
   assign req_done = req_done_q;
   assign req_readdata = rdata_q;
   assign mem_address = mem_address_q;
   assign mem_read = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_burstcount = burst_q;
   assign mem_writedata = wdata_q;
   assign mem_byteenable = be_q;
`ifdef CACHE_STATS_EN
   assign hit_count = hits_q;
   assign miss_count = misses_q;
`endif
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      flush_d = flush_q || (invalidate_all && state_q != IDLE);
      cnt_d = cnt_q;
      line_d = line_q;
      req_done_d = 1'b0;
      rdata_d = rdata_q;
      ram_write_do_d = 1'b0;
      mem_read_d = mem_read_q;
      mem_write_d = mem_write_q;
      mem_address_d = mem_address_q;
      burst_d = burst_q;
      wdata_d = wdata_q;
      be_d = be_q;
      hits_d = hits_q;
      misses_d = misses_q;
      unique case (state_q)
         IDLE: begin
            if (flush_q || invalidate_all) begin
               valid_d = '0;
               flush_d = 1'b0;
            end else if (!req_done_q && req_write) begin
               state_d = WRITE_MEM;
               mem_write_d = 1'b1;
               burst_d = 3'd1;
               mem_address_d = {req_address[ADDR_W-1:2], 2'b00};
               wdata_d = req_writedata;
               be_d = req_byteenable;
            end else if (!req_done_q && req_read) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               state_d = IDLE;
               req_done_d = 1'b1;
               rdata_d = ram_q[127:0];
               hits_d = hits_q + 32'd1;
            end else begin
               state_d = FILL_REQ;
               mem_read_d = 1'b1;
               burst_d = 3'(FILL_BURST);
               mem_address_d = {req_address[ADDR_W-1:4], 4'h0};
               misses_d = misses_q + 32'd1;
            end
         end
         FILL_REQ: begin
            if (!mem_waitrequest) begin
               state_d = FILL_DATA;
               mem_read_d = 1'b0;
               cnt_d = 2'd0;
            end
         end
         FILL_DATA: begin
            if (mem_readdatavalid) begin
               line_d[{cnt_q, 5'd0} +: 32] = mem_readdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'(FILL_BURST - 1)) begin
                  state_d = FILL_WRITE;
                  ram_write_do_d = 1'b1;
                  req_done_d = 1'b1;
                  rdata_d = line_d;
               end
            end
         end
         FILL_WRITE: begin
            valid_d[idx] = 1'b1;
            state_d = IDLE;
         end
         WRITE_MEM: begin
            if (!mem_waitrequest) begin
               mem_write_d = 1'b0;
               valid_d[idx] = 1'b0;
               req_done_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         flush_q <= 1'b0;
         cnt_q <= '0;
         line_q <= '0;
         req_done_q <= 1'b0;
         rdata_q <= '0;
         ram_write_do_q <= 1'b0;
         mem_read_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_address_q <= '0;
         burst_q <= '0;
         wdata_q <= '0;
         be_q <= '0;
         hits_q <= '0;
         misses_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
         cnt_q <= cnt_d;
         line_q <= line_d;
         req_done_q <= req_done_d;
         rdata_q <= rdata_d;
         ram_write_do_q <= ram_write_do_d;
         mem_read_q <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_address_q <= mem_address_d;
         burst_q <= burst_d;
         wdata_q <= wdata_d;
         be_q <= be_d;
         hits_q <= hits_d;
         misses_q <= misses_d;
      end
   end
endmodule
